// File: rtl/word_parity_check.sv
// Combinational parity check of one word against its carried parity bit.
// Shared with the transmit side; unknown PARITY_TYPE strings disable the check.
module word_parity_check #(
    parameter int    WORD_WIDTH  = 8,
    parameter string PARITY_TYPE = "EVEN"
) (
    input  logic [WORD_WIDTH-1:0] data,
    input  logic                  parity,
    output logic                  word_bad
);

    generate
        if (PARITY_TYPE == "EVEN") begin : g_even
            assign word_bad = ^{data, parity};
        end else if (PARITY_TYPE == "ODD") begin : g_odd
            assign word_bad = ~(^{data, parity});
        end else begin : g_none
            assign word_bad = 1'b0 & (^{data, parity});
        end
    endgenerate

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming receive-side checker: per-word parity, frame trailer (column XOR)
// compare, error tagging on the output stream and a saturating bad-frame count.
//
// state | meaning
// IDLE  | no frame open; next accepted word starts a frame
// BODY  | at least one non-last word of the current frame accepted
module parity_frame_checker #(
    parameter int    WORD_WIDTH  = 8,
    parameter string PARITY_TYPE = "EVEN",
    parameter int    COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  in_data,
    input  logic                   in_parity,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   out_word_error,
    output logic                   out_frame_error,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam bit CHECK_EN = (PARITY_TYPE == "EVEN") || (PARITY_TYPE == "ODD");

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] acc;
    logic                  frame_word_bad;
    logic                  word_bad;
    logic                  accept;
    logic                  trailer_bad;
    logic                  frame_bad;
    logic [WORD_WIDTH-1:0] trailer_ref;

    word_parity_check #(
        .WORD_WIDTH  (WORD_WIDTH),
        .PARITY_TYPE (PARITY_TYPE)
    ) u_word_parity_check (
        .data     (in_data),
        .parity   (in_parity),
        .word_bad (word_bad)
    );

    // Combinational ready from out_ready lets the register reload with no bubble.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        trailer_ref = '0;
        if (state == BODY) begin
            trailer_ref = acc;
        end
        trailer_bad = CHECK_EN && (in_data != trailer_ref);
        frame_bad   = frame_word_bad | word_bad | trailer_bad;
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state           <= IDLE;
            acc             <= '0;
            frame_word_bad  <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_last        <= 1'b0;
            out_word_error  <= 1'b0;
            out_frame_error <= 1'b0;
            error_count     <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_data       <= in_data;
            out_last       <= in_last;
            out_word_error <= word_bad;
            if (in_last) begin
                out_frame_error <= frame_bad;
                acc             <= '0;
                frame_word_bad  <= 1'b0;
                state           <= IDLE;
                if (frame_bad && (error_count != {COUNT_WIDTH{1'b1}})) begin
                    error_count <= error_count + 1'b1;
                end
            end else begin
                out_frame_error <= 1'b0;
                acc             <= acc ^ in_data;
                frame_word_bad  <= frame_word_bad | word_bad;
                state           <= BODY;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker (8-bit EVEN) plus a 2-bit-counter
// instance for saturation.
module tb_parity_frame_checker;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       in_valid, in_parity, in_last, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_last, out_word_error, out_frame_error;
    logic [7:0] out_data;
    logic [7:0] error_count;

    logic       s_in_valid, s_in_parity, s_in_last, s_in_ready;
    logic [7:0] s_in_data;
    logic       s_out_valid, s_out_ready, s_out_last, s_out_word_error, s_out_frame_error;
    logic [7:0] s_out_data;
    logic [1:0] s_error_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       werr;
        logic       ferr;
        logic [7:0] count;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc   = '0;
    logic       m_fwb   = 1'b0;
    logic [7:0] m_count = '0;
    int         popped  = 0;

    always #5 clock = ~clock;

    parity_frame_checker #(.WORD_WIDTH(8), .PARITY_TYPE("EVEN"), .COUNT_WIDTH(8)) dut (
        .clock(clock), .clear_n(clear_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_parity(in_parity), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_word_error(out_word_error),
        .out_frame_error(out_frame_error), .error_count(error_count)
    );

    parity_frame_checker #(.WORD_WIDTH(8), .PARITY_TYPE("EVEN"), .COUNT_WIDTH(2)) dut_sat (
        .clock(clock), .clear_n(clear_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_parity(s_in_parity), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_last(s_out_last), .out_word_error(s_out_word_error),
        .out_frame_error(s_out_frame_error), .error_count(s_error_count)
    );

    // Output monitor: every transfer is matched against the scoreboard head.
    always @(negedge clock) begin
        if (clear_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got data %h with nothing expected", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                popped++;
                if (out_data !== e.data || out_last !== e.last || out_word_error !== e.werr ||
                    out_frame_error !== e.ferr || error_count !== e.count) begin
                    errors++;
                    $display("FAIL sb_word: got d=%h l=%b we=%b fe=%b cnt=%0d, want d=%h l=%b we=%b fe=%b cnt=%0d",
                             out_data, out_last, out_word_error, out_frame_error, error_count,
                             e.data, e.last, e.werr, e.ferr, e.count);
                end
            end
        end
    end

    task automatic model_push(input logic [7:0] d, input logic p, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        e.werr = ^{d, p};
        if (l) begin
            e.ferr = m_fwb | e.werr | (d != m_acc);
            if (e.ferr && m_count != 8'hFF) m_count = m_count + 8'd1;
            m_acc = '0;
            m_fwb = 1'b0;
        end else begin
            e.ferr = 1'b0;
            m_acc  = m_acc ^ d;
            m_fwb  = m_fwb | e.werr;
        end
        e.count = m_count;
        sb.push_back(e);
    endtask

    // Presents one word and holds it until accepted (bounded).
    task automatic send(input logic [7:0] d, input logic p, input logic l);
        int  cyc  = 0;
        bit  done = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_parity = p;
        in_last   = l;
        while (!done) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                model_push(d, p, l);
                done = 1;
            end else if (++cyc > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=%b for data %h, want 1", in_ready, d);
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear_n = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
            out_word_error !== 1'b0 || out_frame_error !== 1'b0 || error_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: v=%b d=%h l=%b we=%b fe=%b cnt=%0d, want all 0",
                     out_valid, out_data, out_last, out_word_error, out_frame_error, error_count);
        end
        checks++;
        if (in_ready !== 1'b1 || s_error_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b s_cnt=%0d, want 1 and 0", in_ready, s_error_count);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_good_frame();
        send(8'h01, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01) begin
            errors++;
            $display("FAIL good_latency: v=%b d=%h, want 1 and 01", out_valid, out_data);
        end
        send(8'h02, 1'b1, 1'b0);
        send(8'h03, 1'b0, 1'b1);
        drain("good");
        checks++;
        if (error_count !== 8'd0) begin
            errors++;
            $display("FAIL good_count: got %0d, want 0", error_count);
        end
    endtask

    task automatic test_word_error();
        send(8'h07, 1'b0, 1'b0);
        send(8'h07, 1'b1, 1'b1);
        drain("word_err");
        checks++;
        if (error_count !== 8'd1) begin
            errors++;
            $display("FAIL word_err_count: got %0d, want 1", error_count);
        end
    endtask

    task automatic test_trailer_mismatch();
        send(8'h10, 1'b1, 1'b0);
        send(8'h20, 1'b1, 1'b0);
        send(8'h31, 1'b1, 1'b1);
        drain("trailer");
        checks++;
        if (error_count !== 8'd2) begin
            errors++;
            $display("FAIL trailer_count: got %0d, want 2", error_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] words [4];
        int         start_pop;
        words     = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        start_pop = popped;
        fork
            begin
                for (int i = 0; i < 4; i++) send(words[i], ^words[i], (i == 3));
            end
            begin
                @(posedge clock);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA0) begin
                        errors++;
                        $display("FAIL stall_hold: in_ready=%b v=%b d=%h, want 0 1 a0",
                                 in_ready, out_valid, out_data);
                    end
                    @(posedge clock);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain("backpressure");
        checks++;
        if (popped - start_pop !== 4 || error_count !== 8'd2) begin
            errors++;
            $display("FAIL stall_delivery: delivered %0d cnt=%0d, want 4 and 2",
                     popped - start_pop, error_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        send(8'hFF, 1'b0, 1'b0);
        clear_n = 1'b0;
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        sb.delete();
        m_acc   = '0;
        m_fwb   = 1'b0;
        m_count = '0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || error_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_state: v=%b cnt=%0d, want 0 and 0", out_valid, error_count);
        end
        @(posedge clock);
        #1;
        send(8'h00, 1'b0, 1'b1);
        checks++;
        if (out_frame_error !== 1'b0 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL midreset_frame: fe=%b l=%b, want 0 and 1", out_frame_error, out_last);
        end
        drain("midreset");
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        for (int i = 0; i < 5; i++) begin
            want        = (i < 3) ? 2'(i + 1) : 2'd3;
            s_in_valid  = 1'b1;
            s_in_data   = 8'h01;
            s_in_parity = 1'b0;
            s_in_last   = 1'b1;
            @(posedge clock);
            #1;
            s_in_valid = 1'b0;
            @(negedge clock);
            checks++;
            if (s_error_count !== want || s_out_frame_error !== 1'b1 || s_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sat_count[%0d]: cnt=%0d fe=%b v=%b, want %0d 1 1",
                         i, s_error_count, s_out_frame_error, s_out_valid, want);
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        clear_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_parity   = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_in_parity = 1'b0;
        s_in_last   = 1'b0;
        s_out_ready = 1'b1;
        test_reset();
        test_good_frame();
        test_word_error();
        test_trailer_mismatch();
        test_backpressure();
        test_reset_mid_frame();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Receive-side partner of the team's parity/bit-reduction logic: a streaming checker that accepts words carrying a generator-supplied parity bit. It verifies each word's parity and checks a frame-level trailer word (column XOR of all preceding words in the frame). It also tags errors on the outgoing stream and keeps a saturating count of bad frames. It sits between a parity-generating link/FIFO and downstream consumers, with valid/ready handshakes on both sides.

## Interface
- `WORD_WIDTH`, 8, data bits per word (≥1).
- `PARITY_TYPE`, "EVEN", string. "EVEN" means XOR of {data, parity} must be 0; "ODD" means it must be 1.
- `COUNT_WIDTH`, 8, width of the bad-frame counter (≥1).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `clear_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  checker can accept the word.
- `in_data`  in  WORD_WIDTH  data word.
- `in_parity`  in  1  parity bit for `in_data`.
- `in_last`  in  1  marks the trailer word, which ends the frame.
- `out_valid`  out  1  output word present.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WORD_WIDTH  registered copy of `in_data`.
- `out_last`  out  1  registered copy of `in_last`.
- `out_word_error`  out  1  this word failed its parity check.
- `out_frame_error`  out  1  asserted only with `out_last`: the frame had any word error, or the trailer did not match.
- `error_count`  out  COUNT_WIDTH  bad frames seen, saturating.

## Operation
- Accept occurs when `in_valid & in_ready`. Output transfer occurs when `out_valid & out_ready`.
- Word check: `word_bad = (^{in_data,in_parity}) != (PARITY_TYPE=="ODD")`.
- Any other `PARITY_TYPE` value: no check logic is generated, and the error outputs stay 0.
- State machine:
  - IDLE: no frame open.
  - BODY: at least one non-last word accepted.
  - IDLE→BODY: accept with `in_last=0`.
  - BODY→IDLE: accept with `in_last=1`.
  - Accept with `in_last=1` in IDLE is a single-word frame; the state stays IDLE.
- Accumulator `acc[WORD_WIDTH]` and sticky flag `frame_word_bad`:
  - On a non-last accept: `acc ^= in_data`; `frame_word_bad |= word_bad`.
  - On a last accept: `trailer_bad = (in_data != acc)`; `out_frame_error = frame_word_bad | word_bad | trailer_bad`; `acc` and `frame_word_bad` clear to 0.
  - The trailer word's own parity bit is checked like any other word.
- `error_count` increments by 1 on each last accept whose `out_frame_error` is 1. It holds at all-ones and never wraps.
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_word_error`=0, `out_frame_error`=0, `error_count`=0, `acc`=0, `frame_word_bad`=0, state=IDLE.
- Reset mid-frame discards the partial frame with no error counted. The next accepted word starts a new frame.

## Timing
- Output is a single registered stage: latency is 1 cycle from accept to `out_valid`.
- Throughput is 1 word/cycle while `out_ready`=1.
- `in_ready = ~out_valid | out_ready`. This combinational path from `out_ready` is permitted and documented.
- Simultaneous output transfer and input accept: the output register reloads in the same cycle with no bubble.
- Backpressure: while `out_valid & ~out_ready`, all `out_*` hold stable and no accept occurs.
- `error_count` updates on the same edge that loads the trailer into the output register. It is visible in the same cycle as that trailer's `out_valid`.
- `clear_n` low overrides any concurrent accept or transfer.

## Structure
- No shared package is needed. State encodings (IDLE/BODY) are local constants.
- The accepted `PARITY_TYPE` strings ("EVEN"/"ODD") are documented alongside the matching generator.
- One sub-module: `word_parity_check`, a combinational XOR reduction of {data, parity} against `PARITY_TYPE`, producing `word_bad`. It is reusable by the transmit side.

## Test plan
All scenarios use WORD_WIDTH=8, EVEN, COUNT_WIDTH=8, `out_ready`=1 unless stated.
- Good frame: 0x01/p1, 0x02/p1, trailer 0x03/p0 (last) → three outputs, each 1 cycle after accept; no error flags; `out_last` on 0x03; `error_count`=0.
- Word error: 0x07/p0 then trailer 0x07/p1 → `out_word_error`=1 on the first word only; `out_frame_error`=1 on the trailer; `error_count`=1.
- Trailer mismatch: 0x10/p1, 0x20/p1, trailer 0x31/p1 → no word errors; `out_frame_error`=1; `error_count` increments by exactly 1.
- Backpressure: stream 4 words and hold `out_ready`=0 for 3 cycles after the first accept → `in_ready`=0 during the stall; `out_data` stays stable; all 4 words delivered in order with no loss or duplication.
- Reset mid-frame: accept 0xFF/p0, pulse `clear_n` low for 1 cycle, then single-word frame 0x00/p0 last → `out_valid`=0 after reset; the new frame reports `out_frame_error`=0; `error_count`=0.
- Saturation: COUNT_WIDTH=2, five bad frames → `error_count` sequence 1, 2, 3, 3, 3.
